// File: rtl/md_ctrl.sv
// md_ctrl: HI/LO multiply/divide sequencer with busy counter and D-stage stall request.
// Define MD_CANCEL_EN to add the md_cancel flush input.
module md_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MD_CANCEL_EN
  input  logic        md_cancel,
`endif
  input  logic        E_start,
  input  logic [2:0]  E_md_op,
  input  logic [31:0] E_rs,
  input  logic [31:0] E_rt,
  input  logic        D_use_md,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        busy,
  output logic        stall
);
  typedef enum logic {IDLE, BUSY} state_t;
  localparam logic [3:0] MC = 4'(MULT_CYCLES);
  localparam logic [3:0] DC = 4'(DIV_CYCLES);
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [31:0] pend_hi, pend_lo;
  logic cancel, md_start, go;
`ifdef MD_CANCEL_EN
  assign cancel = md_cancel;
`else
  assign cancel = 1'b0;
`endif
  assign md_start = E_start & ~E_md_op[2];
  assign go = md_start & ~cancel;
  assign busy = state == BUSY;
  assign stall = D_use_md & (busy | md_start);
  logic signed [63:0] prod_s;
  logic [63:0] prod_u;
  assign prod_s = $signed(E_rs) * $signed(E_rt);
  assign prod_u = {32'b0, E_rs} * {32'b0, E_rt};
  // Divide on magnitudes so INT_MIN / -1 never reaches a signed divider.
  logic sgn;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quo, rem;
  assign sgn = ~E_md_op[0];
  assign a_mag = (sgn & E_rs[31]) ? -E_rs : E_rs;
  assign b_mag = (sgn & E_rt[31]) ? -E_rt : E_rt;
  assign q_mag = a_mag / b_mag;
  assign r_mag = a_mag % b_mag;
  assign quo = (sgn & (E_rs[31] ^ E_rt[31])) ? -q_mag : q_mag;
  assign rem = (sgn & E_rs[31]) ? -r_mag : r_mag;
  logic [63:0] res;
  assign res = E_md_op[1] ? ((E_rt == 32'd0) ? {HI, LO} : {rem, quo})
                          : (E_md_op[0] ? prod_u : prod_s);
  always_comb begin
    state_nx = state;
    if (state == IDLE && go) state_nx = BUSY;
    if (state == BUSY && (cnt == 4'd1 || cancel)) state_nx = IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      HI <= '0;
      LO <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
    end else if (state == IDLE) begin
      if (go) begin
        {pend_hi, pend_lo} <= res;
        cnt <= E_md_op[1] ? DC : MC;
      end else if (E_start && !cancel && E_md_op == 3'd4) HI <= E_rs;
      else if (E_start && !cancel && E_md_op == 3'd5) LO <= E_rs;
    end else begin
      cnt <= cancel ? 4'd0 : cnt - 4'd1;
      if (cnt == 4'd1 && !cancel) begin
        HI <= pend_hi;
        LO <= pend_lo;
      end
    end
endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed self-checking bench for md_ctrl.
module tb_md_ctrl;
  logic clk, reset, E_start, D_use_md;
  logic [2:0] E_md_op;
  logic [31:0] E_rs, E_rt, HI, LO;
  logic busy, stall;
  int n_chk, n_fail;
`ifdef MD_CANCEL_EN
  logic md_cancel;
`endif

  md_ctrl dut (
    .clk(clk), .reset(reset),
`ifdef MD_CANCEL_EN
    .md_cancel(md_cancel),
`endif
    .E_start(E_start), .E_md_op(E_md_op), .E_rs(E_rs), .E_rt(E_rt),
    .D_use_md(D_use_md), .HI(HI), .LO(LO), .busy(busy), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, required end before 300000");
    $fatal(1);
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt);
    @(negedge clk);
    E_start = 1'b1; E_md_op = op; E_rs = rs; E_rt = rt;
    @(negedge clk);
    E_start = 1'b0;
  endtask

  task automatic run_busy(output int n);
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_chk++; if (HI !== 32'h0) begin n_fail++; $display("FAIL rst_hi: got %h want 0", HI); end
    n_chk++; if (LO !== 32'h0) begin n_fail++; $display("FAIL rst_lo: got %h want 0", LO); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    D_use_md = 1'b1; E_start = 1'b1; E_md_op = 3'd2; #1;
    n_chk++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rst_stall_start: got %b want 1", stall); end
    E_start = 1'b0; #1;
    n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall_idle: got %b want 0", stall); end
    D_use_md = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset_mid_div;
    issue(3'd4, 32'hAA, 32'h0);
    issue(3'd5, 32'hBB, 32'h0);
    issue(3'd2, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_chk++; if (HI !== 32'h0) begin n_fail++; $display("FAIL arst_hi: got %h want 0", HI); end
    n_chk++; if (LO !== 32'h0) begin n_fail++; $display("FAIL arst_lo: got %h want 0", LO); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b want 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    n_chk++; if (LO !== 32'h0) begin n_fail++; $display("FAIL arst_nocommit_lo: got %h want 0", LO); end
    n_chk++; if (HI !== 32'h0) begin n_fail++; $display("FAIL arst_nocommit_hi: got %h want 0", HI); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL arst_nocommit_busy: got %b want 0", busy); end
  endtask

  task automatic test_mult;
    int n;
    issue(3'd0, 32'hFFFFFFFE, 32'd3);
    run_busy(n);
    n_chk++; if (n != 5) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d want 5", n); end
    n_chk++; if (HI !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", HI); end
    n_chk++; if (LO !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL mult_lo: got %h want fffffffa", LO); end
    issue(3'd1, 32'hFFFFFFFE, 32'd3);
    run_busy(n);
    n_chk++; if (n != 5) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d want 5", n); end
    n_chk++; if (HI !== 32'h2) begin n_fail++; $display("FAIL multu_hi: got %h want 00000002", HI); end
    n_chk++; if (LO !== 32'hFFFFFFFA) begin n_fail++; $display("FAIL multu_lo: got %h want fffffffa", LO); end
  endtask

  task automatic test_div;
    int n;
    issue(3'd2, 32'hFFFFFFF9, 32'd2);
    run_busy(n);
    n_chk++; if (n != 10) begin n_fail++; $display("FAIL div_busy_cycles: got %0d want 10", n); end
    n_chk++; if (LO !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_lo: got %h want fffffffd", LO); end
    n_chk++; if (HI !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_hi: got %h want ffffffff", HI); end
    issue(3'd3, 32'd100, 32'd7);
    run_busy(n);
    n_chk++; if (LO !== 32'd14) begin n_fail++; $display("FAIL divu_lo: got %h want 0000000e", LO); end
    n_chk++; if (HI !== 32'd2) begin n_fail++; $display("FAIL divu_hi: got %h want 00000002", HI); end
    issue(3'd4, 32'h11, 32'h0);
    issue(3'd5, 32'h22, 32'h0);
    issue(3'd3, 32'd7, 32'd0);
    run_busy(n);
    n_chk++; if (n != 10) begin n_fail++; $display("FAIL div0_busy_cycles: got %0d want 10", n); end
    n_chk++; if (HI !== 32'h11) begin n_fail++; $display("FAIL div0_hi: got %h want 00000011", HI); end
    n_chk++; if (LO !== 32'h22) begin n_fail++; $display("FAIL div0_lo: got %h want 00000022", LO); end
    issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
    run_busy(n);
    n_chk++; if (LO !== 32'h80000000) begin n_fail++; $display("FAIL divovf_lo: got %h want 80000000", LO); end
    n_chk++; if (HI !== 32'h0) begin n_fail++; $display("FAIL divovf_hi: got %h want 0", HI); end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    E_start = 1'b1; E_md_op = 3'd4; E_rs = 32'h1234;
    @(negedge clk);
    n_chk++; if (HI !== 32'h1234) begin n_fail++; $display("FAIL mthi: got %h want 00001234", HI); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy: got %b want 0", busy); end
    E_md_op = 3'd5; E_rs = 32'h5678;
    @(negedge clk);
    n_chk++; if (LO !== 32'h5678) begin n_fail++; $display("FAIL mtlo: got %h want 00005678", LO); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mtlo_busy: got %b want 0", busy); end
    E_md_op = 3'd6; E_rs = 32'hDEAD;
    @(negedge clk);
    E_start = 1'b0;
    n_chk++; if ({HI, LO} !== {32'h1234, 32'h5678}) begin n_fail++; $display("FAIL reserved_op: got %h want 0000123400005678", {HI, LO}); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reserved_busy: got %b want 0", busy); end
  endtask

  task automatic test_busy_ignore;
    int n;
    issue(3'd0, 32'd2, 32'd3);
    E_start = 1'b1; E_md_op = 3'd4; E_rs = 32'hDEAD;
    @(negedge clk);
    E_md_op = 3'd2; E_rs = 32'd9; E_rt = 32'd1;
    @(negedge clk);
    E_start = 1'b0;
    run_busy(n);
    n_chk++; if (n != 3) begin n_fail++; $display("FAIL ignore_busy_rest: got %0d want 3", n); end
    n_chk++; if (HI !== 32'h0) begin n_fail++; $display("FAIL ignore_hi: got %h want 0", HI); end
    n_chk++; if (LO !== 32'h6) begin n_fail++; $display("FAIL ignore_lo: got %h want 00000006", LO); end
  endtask

  task automatic test_stall;
    int n;
    @(negedge clk);
    D_use_md = 1'b1; E_start = 1'b1; E_md_op = 3'd0; E_rs = 32'd2; E_rt = 32'd3;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (!stall) break;
      n++;
      @(negedge clk);
      E_start = 1'b0;
    end
    n_chk++; if (n != 6) begin n_fail++; $display("FAIL stall_cycles: got %0d want 6", n); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_end_busy: got %b want 0", busy); end
    @(negedge clk);
    D_use_md = 1'b0; E_start = 1'b1;
    n = 0;
    for (int i = 0; i < 7; i++) begin
      #1;
      if (stall) n++;
      @(negedge clk);
      E_start = 1'b0;
    end
    n_chk++; if (n != 0) begin n_fail++; $display("FAIL stall_no_use: got %0d high cycles want 0", n); end
  endtask

`ifdef MD_CANCEL_EN
  task automatic test_cancel;
    int n;
    issue(3'd4, 32'h11, 32'h0);
    issue(3'd5, 32'h22, 32'h0);
    issue(3'd2, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    md_cancel = 1'b1;
    @(negedge clk);
    md_cancel = 1'b0;
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_busy: got %b want 0", busy); end
    n_chk++; if ({HI, LO} !== {32'h11, 32'h22}) begin n_fail++; $display("FAIL cancel_hold: got %h want 0000001100000022", {HI, LO}); end
    repeat (8) @(negedge clk);
    n_chk++; if ({HI, LO} !== {32'h11, 32'h22}) begin n_fail++; $display("FAIL cancel_nocommit: got %h want 0000001100000022", {HI, LO}); end
    issue(3'd0, 32'd2, 32'd3);
    run_busy(n);
    n_chk++; if (n != 5) begin n_fail++; $display("FAIL cancel_mult_cycles: got %0d want 5", n); end
    n_chk++; if ({HI, LO} !== 64'h6) begin n_fail++; $display("FAIL cancel_mult: got %h want 0000000000000006", {HI, LO}); end
    @(negedge clk);
    md_cancel = 1'b1; E_start = 1'b1; E_md_op = 3'd4; E_rs = 32'h99;
    @(negedge clk);
    E_md_op = 3'd1;
    @(negedge clk);
    md_cancel = 1'b0; E_start = 1'b0;
    n_chk++; if (HI !== 32'h0) begin n_fail++; $display("FAIL cancel_mthi: got %h want 0", HI); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_start: got %b want 0", busy); end
  endtask
`endif

  initial begin
    n_chk = 0; n_fail = 0;
    reset = 1'b1; E_start = 1'b0; E_md_op = 3'd0; E_rs = 32'h0; E_rt = 32'h0; D_use_md = 1'b0;
`ifdef MD_CANCEL_EN
    md_cancel = 1'b0;
`endif
    test_reset;
    test_reset_mid_div;
    test_mult;
    test_div;
    test_back_to_back;
    test_busy_ignore;
    test_stall;
`ifdef MD_CANCEL_EN
    test_cancel;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/md_ctrl.md
Name: md_ctrl

Overview:
- Sequencing controller for the HI/LO multiply/divide resource of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mthi/mtlo ops from the E stage and models the multi-cycle latency with a busy counter.
- Commits results to HI/LO and raises the stall request the hazard unit ORs into its D-stage freeze.
- Sits beside the ALU in E; HI/LO feed the mfhi/mflo path.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- E_start  input  1  valid md op in E this cycle
- E_md_op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 reserved (no-op)
- E_rs  input  32  forwarded rs operand
- E_rt  input  32  forwarded rt operand
- D_use_md  input  1  instruction in D is mult/div/mf*/mt*
- HI  output  32  HI register
- LO  output  32  LO register
- busy  output  1  multi-cycle op in flight
- stall  output  1  = D_use_md & (busy | (E_start & E_md_op<=3))

Behaviour:
- Reset (async, any time, including mid-operation): HI=0, LO=0, busy=0, state=IDLE, counter=0, pending regs=0. stall is then just D_use_md & start-term.
- States: IDLE, BUSY. Internal cnt is 4 bits.
- IDLE, E_start with op 0-3, at the edge:
  - compute the result into pend_hi/pend_lo;
  - cnt = MULT_CYCLES or DIV_CYCLES;
  - go to BUSY.
  - busy=1 from the next cycle onward.
- IDLE, E_start with op 4/5: HI (or LO) = E_rs at the edge; no busy. Reserved ops are ignored.
- BUSY: cnt decrements each edge. At the edge where cnt==1:
  - HI=pend_hi, LO=pend_lo;
  - go to IDLE, busy=0.
  - New values are visible in the first cycle busy is low.
  - Total: a start at edge t commits at edge t+N; busy is high N cycles.
- E_start while BUSY: protocol violation (stall prevents it). Ignored; the in-flight op completes unaffected.
- Arithmetic:
  - mult: {HI,LO} = signed(rs) * signed(rt), 64-bit.
  - multu: same, unsigned.
  - div: LO = signed quotient, HI = signed remainder (remainder sign follows dividend, truncation toward zero).
  - divu: same, unsigned.
- Divide by zero (rt==0): op still takes DIV_CYCLES with busy high; HI/LO unchanged at commit.
- Overflow case div 0x80000000 / -1: LO=0x80000000, HI=0.
- stall is combinational and covers the start cycle itself, so a D-stage md instruction behind a starting mult/div is frozen immediately.

Optional Feature:
- Macro: MD_CANCEL_EN.
- Defined:
  - adds input md_cancel (1 bit, for exception/interrupt flush).
  - md_cancel high at an edge while BUSY: go to IDLE, busy=0, HI/LO keep their pre-op values, pending result discarded.
  - md_cancel high together with E_start in IDLE: the start is suppressed, including mthi/mtlo writes.
  - md_cancel in IDLE without a start: no effect.
- Undefined: port absent; every started op always commits.

Test Plan:
- Reset: assert reset mid-BUSY of a div -> HI=LO=0, busy=0 immediately (async); the div never commits after release.
- mult rs=0xFFFFFFFE (-2), rt=3 -> busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; multu same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- div rs=-7 (0xFFFFFFF9), rt=2 -> busy 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); divu 7/0 with HI=0x11, LO=0x22 -> unchanged after 10 cycles.
- mthi rs=0x1234 then mtlo rs=0x5678 on back-to-back cycles -> HI=0x1234, LO=0x5678 at the following edges; busy never asserts.
- Stall: D_use_md=1 during E_start of mult and its 5 busy cycles -> stall=1 for 6 consecutive cycles, 0 on the 7th; D_use_md=0 -> stall=0 throughout.
- MD_CANCEL_EN: start div, pulse md_cancel at busy cycle 4 -> busy drops next cycle, HI/LO hold prior values; a following mult commits normally.
